// File: rtl/bpg_pkg.sv
// Constants shared by the pattern loader and the output controller.
package bpg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VAR   = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } oc_state_t;

  localparam int HALF_WORDS = 4096;
  localparam logic [12:0] BASE0 = 13'd0;
  localparam logic [12:0] BASE1 = 13'd4096;

  localparam int VAR_DIV_HI = 31;
  localparam int VAR_DIV_LO = 16;
  localparam int VAR_REP_HI = 15;
  localparam int VAR_REP_LO = 0;

  function automatic logic [15:0] var_div(input logic [31:0] v);
    return v[VAR_DIV_HI:VAR_DIV_LO];
  endfunction

  function automatic logic [15:0] var_rep(input logic [31:0] v);
    return v[VAR_REP_HI:VAR_REP_LO];
  endfunction

  function automatic logic [12:0] half_base(input logic half);
    return half ? BASE1 : BASE0;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Word hold counter: counts 0..div while enabled; first/last flag the
// cycle a word is loaded and the cycle its hold ends.
module rate_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] div,
  output logic        first,
  output logic        last
);

  logic [15:0] hold_cnt_q;
  logic [15:0] hold_cnt_d;

  assign first = (hold_cnt_q == 16'd0);
  assign last  = (hold_cnt_q == div);

  // next hold count
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clr) begin
      hold_cnt_d = 16'd0;
    end else if (en) begin
      if (last) begin
        hold_cnt_d = 16'd0;
      end else begin
        hold_cnt_d = hold_cnt_q + 16'd1;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // hold count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt_q <= 16'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/output_control.sv
// Plays the active half of the pattern RAM at a programmable rate and
// swaps halves at pass boundaries once the loader has filled the other one.
module output_control
  import bpg_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int DW         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load_complete,
  output logic                  active_buffer,
  output logic [DEPTH_LOG2:0]   raddr,
  input  logic [DW-1:0]         rdata,
  output logic [3:0]            vaddr,
  input  logic [31:0]           vdata,
  output logic [DW-1:0]         dout,
  output logic                  strobe,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] OFF_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] OFF_LAST = DEPTH_LOG2'(HALF_WORDS - 1);

  oc_state_t             state_q, state_d;
  logic                  ab_q, ab_d;
  logic [AW-1:0]         raddr_q, raddr_d;
  logic [DW-1:0]         dout_q, dout_d;
  logic                  strobe_q, strobe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pending_q, pending_d;
  logic                  lc_prev_q, lc_prev_d;
  logic [15:0]           div_q, div_d;
  logic [15:0]           rep_q, rep_d;
  logic [15:0]           pass_cnt_q, pass_cnt_d;
  logic [DEPTH_LOG2-1:0] out_off_q, out_off_d;
  logic                  word_valid_q, word_valid_d;

  logic lc_rise_s;
  logic consume_s;
  logic do_load_s;
  logic div_first_s;
  logic div_last_s;

  rate_divider u_rate_divider (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_RUN),
    .en    (1'b1),
    .div   (div_q),
    .first (div_first_s),
    .last  (div_last_s)
  );

  assign lc_rise_s = load_complete & ~lc_prev_q;

  // next-state and output decode for playback
  always_comb begin
    state_d      = state_q;
    ab_d         = ab_q;
    raddr_d      = raddr_q;
    dout_d       = dout_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    div_d        = div_q;
    rep_d        = rep_q;
    pass_cnt_d   = pass_cnt_q;
    out_off_d    = out_off_q;
    word_valid_d = word_valid_q;
    consume_s    = 1'b0;
    do_load_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dout_d = {DW{1'b0}};
        if (enable && pending_q) begin
          ab_d      = ~ab_q;
          consume_s = 1'b1;
          state_d   = ST_VAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VAR: begin
        div_d        = var_div(vdata);
        rep_d        = var_rep(vdata);
        pass_cnt_d   = 16'd0;
        raddr_d      = AW'(half_base(ab_q));
        out_off_d    = OFF_LAST;
        word_valid_d = 1'b0;
        state_d      = ST_PRIME;
      end
      ST_PRIME: begin
        raddr_d = {ab_q, OFF_ONE};
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (div_last_s) begin
          raddr_d = {ab_q, raddr_q[DEPTH_LOG2-1:0] + OFF_ONE};
        end else begin
          raddr_d = raddr_q;
        end
        // The hold of the last word of a pass ends here; decide what follows.
        if (div_first_s) begin
          if (word_valid_q && (out_off_q == OFF_LAST)) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
            if (pending_q && enable) begin
              ab_d      = ~ab_q;
              consume_s = 1'b1;
              state_d   = ST_VAR;
            end else if ((rep_q != 16'd0) && ((pass_cnt_q + 16'd1) == rep_q)) begin
              done_d  = 1'b1;
              dout_d  = {DW{1'b0}};
              state_d = ST_IDLE;
            end else if (!enable) begin
              dout_d  = {DW{1'b0}};
              state_d = ST_IDLE;
            end else begin
              do_load_s = 1'b1;
            end
          end else begin
            do_load_s = 1'b1;
          end
        end else begin
          do_load_s = 1'b0;
        end
        if (do_load_s) begin
          dout_d       = rdata;
          strobe_d     = 1'b1;
          out_off_d    = out_off_q + OFF_ONE;
          word_valid_d = 1'b1;
        end else begin
          out_off_d = out_off_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (lc_rise_s) begin
      pending_d = 1'b1;
    end else if (consume_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    lc_prev_d = load_complete;
    busy_d    = (state_d != ST_IDLE);
  end

  // playback state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ab_q         <= 1'b0;
      raddr_q      <= {AW{1'b0}};
      dout_q       <= {DW{1'b0}};
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pending_q    <= 1'b0;
      lc_prev_q    <= 1'b0;
      div_q        <= 16'd0;
      rep_q        <= 16'd0;
      pass_cnt_q   <= 16'd0;
      out_off_q    <= {DEPTH_LOG2{1'b0}};
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ab_q         <= ab_d;
      raddr_q      <= raddr_d;
      dout_q       <= dout_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pending_q    <= pending_d;
      lc_prev_q    <= lc_prev_d;
      div_q        <= div_d;
      rep_q        <= rep_d;
      pass_cnt_q   <= pass_cnt_d;
      out_off_q    <= out_off_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign active_buffer = ab_q;
  assign raddr         = raddr_q;
  assign vaddr         = {3'b000, ab_q};
  assign dout          = dout_q;
  assign strobe        = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_output_control.sv
// Self-checking bench for output_control: the expected output stream is
// computed arithmetically from start time, divider, repeat count and RAM contents.
module tb_output_control;
  import bpg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load_complete;
  logic        active_buffer;
  logic [12:0] raddr;
  logic [15:0] rdata;
  logic [3:0]  vaddr;
  logic [31:0] vdata;
  logic [15:0] dout;
  logic        strobe;
  logic        busy;
  logic        done;

  logic [15:0] mem  [0:8191];
  logic [31:0] vmem [0:15];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int dones = 0;

  output_control #(.DEPTH_LOG2(12), .DW(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .load_complete (load_complete),
    .active_buffer (active_buffer),
    .raddr         (raddr),
    .rdata         (rdata),
    .vaddr         (vaddr),
    .vdata         (vdata),
    .dout          (dout),
    .strobe        (strobe),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];
  assign vdata = vmem[vaddr];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Pulse load_complete for one cycle; the next edge is the go edge.
  task automatic trigger();
    load_complete = 1'b1;
    tick();
    cmp("idle_before_go", {31'd0, busy}, 32'd0);
    load_complete = 1'b0;
  endtask

  // c counts edges since the edge that starts this half (c=0 is that edge).
  // Word k of a pass appears c = 3 + k*(div+1), playback ends after passes*4096 words.
  task automatic play(input string name, input int half, input int div, input int passes,
                      input int c0, input int c1, input logic [15:0] prev, input bit end_done);
    logic [23:0] exp_v, got_v;
    logic        hb;
    int n, per, total, w;
    hb  = half[0];
    per = div + 1;
    total = passes * HALF_WORDS * per;
    for (int c = c0; c < c1; c++) begin
      tick();
      n = c - 3;
      if (n < 0) begin
        exp_v = {3'b000, hb, hb, 1'b1, 1'b0, 1'b0, prev};
      end else if (passes == 0 || n < total) begin
        w = (n / per) % HALF_WORDS;
        exp_v = {3'b000, hb, hb, 1'b1, 1'b0, (n % per == 0), mem[half * HALF_WORDS + w]};
      end else if (n == total) begin
        exp_v = {3'b000, hb, hb, 1'b0, end_done, 1'b0, 16'h0000};
      end else begin
        exp_v = {3'b000, hb, hb, 1'b0, 1'b0, 1'b0, 16'h0000};
      end
      got_v = {vaddr, active_buffer, busy, done, strobe, dout};
      cmp(name, {8'd0, got_v}, {8'd0, exp_v});
      if (strobe) strobes++;
      if (done) dones++;
    end
  endtask

  typedef struct {
    int div;
    int rep;
    int half;
    int exp_strobes;
    int exp_dones;
  } vec_t;

  initial begin
    vec_t vecs [3];
    logic [15:0] last1, last0;

    vecs[0] = '{div: 0, rep: 1, half: 1, exp_strobes: 4096, exp_dones: 1};
    vecs[1] = '{div: 3, rep: 2, half: 0, exp_strobes: 8192, exp_dones: 1};
    vecs[2] = '{div: int'($urandom_range(0, 2)), rep: 1, half: 1, exp_strobes: 4096, exp_dones: 1};

    for (int i = 0; i < 4096; i++) begin
      mem[4096 + i] = 16'(i);
      mem[i]        = 16'($urandom);
    end
    for (int i = 0; i < 16; i++) vmem[i] = 32'd0;
    last1 = mem[8191];
    last0 = mem[4095];

    reset = 1'b0;
    enable = 1'b1;
    load_complete = 1'b0;
    tick();
    tick();
    cmp("reset_state", {12'd0, raddr, vaddr, active_buffer, busy, done, strobe},
        32'd0);
    cmp("reset_dout", {16'd0, dout}, 32'd0);
    reset = 1'b1;
    tick();
    cmp("idle_no_pending", {30'd0, busy, strobe}, 32'd0);

    // Table: full-pass playback with several divider / repeat settings.
    for (int i = 0; i < 3; i++) begin
      vmem[vecs[i].half] = {16'(vecs[i].div), 16'(vecs[i].rep)};
      strobes = 0;
      dones = 0;
      trigger();
      play("table_play", vecs[i].half, vecs[i].div, vecs[i].rep, 0,
           3 + vecs[i].rep * HALF_WORDS * (vecs[i].div + 1) + 3, 16'h0000, 1'b1);
      cmp("table_strobes", 32'(strobes), 32'(vecs[i].exp_strobes));
      cmp("table_dones", 32'(dones), 32'(vecs[i].exp_dones));
    end

    // Swap requested mid-pass on an endless half, then enable dropped.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vmem[1] = {16'd0, 16'd0};
    trigger();
    play("forever_h1", 1, 0, 0, 0, 1000, 16'h0000, 1'b0);
    vmem[0] = {16'd1, 16'd0};
    load_complete = 1'b1;
    play("forever_h1", 1, 0, 0, 1000, 1001, 16'h0000, 1'b0);
    load_complete = 1'b0;
    play("forever_h1", 1, 0, 0, 1001, 4099, 16'h0000, 1'b0);
    dones = 0;
    play("swap_h0", 0, 1, 1, 0, 203, last1, 1'b0);
    enable = 1'b0;
    play("enable_drop", 0, 1, 1, 203, 3 + 8192 + 3, last1, 1'b0);
    cmp("enable_drop_dones", 32'(dones), 32'd0);
    enable = 1'b1;
    tick();
    cmp("enable_drop_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a pass aborts and forgets the start.
    vmem[1] = {16'd0, 16'd0};
    trigger();
    play("pre_reset", 1, 0, 0, 0, 2004, 16'h0000, 1'b0);
    reset = 1'b0;
    tick();
    cmp("reset_mid_state", {12'd0, raddr, vaddr, active_buffer, busy, done, strobe},
        32'd0);
    cmp("reset_mid_dout", {16'd0, dout}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      cmp("no_restart", {29'd0, busy, done, strobe}, 32'd0);
    end

    // load_complete coincident with the end-of-pass swap re-arms pending.
    vmem[1] = {16'd0, 16'd0};
    vmem[0] = {16'd0, 16'd0};
    trigger();
    play("coinc_h1", 1, 0, 0, 0, 500, 16'h0000, 1'b0);
    load_complete = 1'b1;
    play("coinc_h1", 1, 0, 0, 500, 501, 16'h0000, 1'b0);
    load_complete = 1'b0;
    play("coinc_h1", 1, 0, 0, 501, 4099, 16'h0000, 1'b0);
    load_complete = 1'b1;
    play("coinc_h0", 0, 0, 0, 0, 1, last1, 1'b0);
    load_complete = 1'b0;
    play("coinc_h0", 0, 0, 0, 1, 4099, last1, 1'b0);
    play("second_swap", 1, 0, 0, 0, 8, last0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
